sweep_step_ctrl: RTL and testbench
==================================

# sweep_step_ctrl

Automatic frequency-sweep sequencer for the waveform generator. Replaces manual button stepping with a scheduled ramp of the NCO phase-count step between programmable bounds, holding each step value for a programmable dwell. Its output drives the phase-accumulator step input of the wave path, and its update pulse tells downstream logic that a new step is active.

## Interface
- DEPTH, 1024, waveform LUT depth; AW = $clog2(DEPTH) is the step width
- DWELL_W, 16, width of the dwell counter
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; latch config and begin sweep
- i_stop  in  1  single-cycle pulse; abort sweep
- i_hold  in  1  level; freeze sweep while high
- i_step_min  in  AW  lower sweep bound
- i_step_max  in  AW  upper sweep bound
- i_step_inc  in  AW  increment per step event
- i_dwell  in  DWELL_W  cycles each value is held; 0 is treated as 1
- o_phase_count_step  out  AW  current step to the NCO (registered)
- o_step_update  out  1  one-cycle pulse, coincident with each newly loaded step value
- o_busy  out  1  high in RUN or HOLD
- o_dir  out  1  1 = ramping up, 0 = ramping down
- o_period_done  out  1  one-cycle pulse when a full sweep period completes
- o_cfg_err  out  1  one-cycle pulse when i_start is rejected

## Operation
- States: IDLE, RUN, HOLD. Reset: IDLE, o_phase_count_step=0, o_dir=1, all pulses and o_busy=0.
- IDLE + i_start: latch min/max/inc/dwell (D = max(i_dwell,1)). If min > max or inc == 0, pulse o_cfg_err and stay IDLE. Otherwise load step=min, dir=1, dwell counter=D, pulse o_step_update, go RUN.
- RUN: dwell counter decrements each cycle; at count==1 a step event occurs: compute next value, load it, reload counter to D, pulse o_step_update.
- Step event, dir=1: if cur != max, next = min(cur+inc, max), computed in AW+1 bits (no wrap). If cur == max, behaviour set by the configuration macro.
- Step event, dir=0: if cur != min, next = max(cur-inc, min), computed in AW+1 bits (signed compare). If cur == min, set dir=1, next = min(cur+inc, max), pulse o_period_done.
- min == max: value is constant. Step events and pulses still occur per the rules above.
- RUN + i_hold: go HOLD; counter and value are frozen. HOLD + !i_hold: return to RUN with the remaining count.
- i_stop in RUN/HOLD: go IDLE. o_phase_count_step keeps its last value. No update pulse is generated.
- i_stop has priority over i_start in the same cycle. i_start while busy is ignored. Input config changes while busy are ignored.

## Timing
- i_start in cycle N: in cycle N+1, step=min, o_step_update=1, o_busy=1. o_cfg_err, on rejection, is also in cycle N+1.
- Each value is held exactly D RUN cycles. Held cycles are excluded from that count.
- o_period_done is asserted in the same cycle as the o_step_update of the value that begins the new period.
- i_stop in cycle N: o_busy=0 in cycle N+1.
- Reset asserted mid-sweep: all outputs take their reset values immediately (asynchronous).

## Configuration
- SWEEP_BIDIR_EN defined: triangle sweep. At cur == max on an up-step event: dir=0, next = max(cur-inc, min), no period pulse.
- SWEEP_BIDIR_EN undefined: sawtooth sweep. At cur == max: next = min, dir stays 1, o_period_done pulses. o_dir is then constantly 1.

## Test plan
- Sawtooth (macro off), min=10, max=40, inc=10, dwell=3 -> values 10,20,30,40,10, each held 3 cycles; o_step_update on each load; o_period_done with the second 10.
- Triangle (macro on), same config -> values 10,20,30,40,30,20,10,20; o_dir falls on the load of 30 after 40; o_period_done with the 20 that follows 10.
- Clamp: min=0, max=25, inc=10, dwell=1, macro off -> 0,10,20,25,0 on consecutive cycles.
- Config error: min=50, max=40 (and separately inc=0) -> o_cfg_err pulse one cycle after i_start; o_busy stays 0; step unchanged.
- Hold/stop: min=10, max=40, inc=10, dwell=4; assert i_hold 2 cycles into value 20 for 5 cycles -> 20 held 9 cycles total; then pulse i_stop -> o_busy=0 next cycle, step frozen at last value, no further pulses.
- Reset mid-sweep, and i_start+i_stop together in IDLE -> all outputs return to reset values; the simultaneous start/stop leaves the block in IDLE.

Source files
------------

// File: rtl/sweep_step_ctrl_if.sv
// Sweep sequencer control/status bundle: start/stop/hold controls, sweep
// configuration and the step/pulse outputs toward the NCO wave path.
interface sweep_step_ctrl_if #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned DWELL_W = 16
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic               i_start;
   logic               i_stop;
   logic               i_hold;
   logic [AW-1:0]      i_step_min;
   logic [AW-1:0]      i_step_max;
   logic [AW-1:0]      i_step_inc;
   logic [DWELL_W-1:0] i_dwell;
   logic [AW-1:0]      o_phase_count_step;
   logic               o_step_update;
   logic               o_busy;
   logic               o_dir;
   logic               o_period_done;
   logic               o_cfg_err;

   modport master (
      output i_start, i_stop, i_hold, i_step_min, i_step_max, i_step_inc, i_dwell,
      input  o_phase_count_step, o_step_update, o_busy, o_dir, o_period_done, o_cfg_err
   );

   modport slave (
      input  i_start, i_stop, i_hold, i_step_min, i_step_max, i_step_inc, i_dwell,
      output o_phase_count_step, o_step_update, o_busy, o_dir, o_period_done, o_cfg_err
   );
endinterface

// File: rtl/sweep_step_ctrl.sv
// Automatic frequency-sweep sequencer: ramps the NCO phase-count step between
// latched bounds, holding each value for a programmable dwell.
// Build option: define SWEEP_BIDIR_EN for a triangle sweep; default is sawtooth.
module sweep_step_ctrl #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned DWELL_W = 16
) (
   input logic              i_clk,
   input logic              i_rst_n,
   sweep_step_ctrl_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      step_q, step_d;
   logic [AW-1:0]      min_q, min_d;
   logic [AW-1:0]      max_q, max_d;
   logic [AW-1:0]      inc_q, inc_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               upd_q, upd_d;
   logic               pdone_q, pdone_d;
   logic               cerr_q, cerr_d;

   logic [AW:0]        sum_w;
   logic [AW:0]        diff_w;
   logic [AW-1:0]      up_next;
   logic [AW-1:0]      dn_next;
   logic [DWELL_W-1:0] dwell_eff;

   // Clamped up/down candidates, one bit wider so large increments never wrap
   always_comb begin
      sum_w   = {1'b0, step_q} + {1'b0, inc_q};
      diff_w  = {1'b0, step_q} - {1'b0, inc_q};
      up_next = (sum_w > {1'b0, max_q}) ? max_q : sum_w[AW-1:0];
      dn_next = ($signed(diff_w) < $signed({1'b0, min_q})) ? min_q : diff_w[AW-1:0];
   end

   // Next-state, config latch, counter and pulse generation
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      min_d     = min_q;
      max_d     = max_q;
      inc_d     = inc_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      upd_d     = 1'b0;
      pdone_d   = 1'b0;
      cerr_d    = 1'b0;
      dwell_eff = (bus.i_dwell == '0) ? DWELL_W'(1) : bus.i_dwell;

      unique case (state_q)
         StIdle: begin
            // Stop wins over a coincident start
            if (bus.i_start && !bus.i_stop) begin
               min_d   = bus.i_step_min;
               max_d   = bus.i_step_max;
               inc_d   = bus.i_step_inc;
               dwell_d = dwell_eff;
               if ((bus.i_step_min > bus.i_step_max) || (bus.i_step_inc == '0)) begin
                  cerr_d = 1'b1;
               end else begin
                  step_d  = bus.i_step_min;
                  dir_d   = 1'b1;
                  cnt_d   = dwell_eff;
                  upd_d   = 1'b1;
                  state_d = StRun;
               end
            end
         end
         StRun, StHold: begin
            if (bus.i_stop) begin
               state_d = StIdle;
            end else if (bus.i_hold) begin
               state_d = StHold;
            end else begin
               // A cycle leaving HOLD counts as a running cycle
               state_d = StRun;
               if (cnt_q > DWELL_W'(1)) begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end else begin
                  cnt_d = dwell_q;
                  upd_d = 1'b1;
                  if (dir_q) begin
                     if (step_q != max_q) begin
                        step_d = up_next;
                     end else begin
`ifdef SWEEP_BIDIR_EN
                        dir_d  = 1'b0;
                        step_d = dn_next;
`else
                        step_d  = min_q;
                        pdone_d = 1'b1;
`endif
                     end
                  end else if (step_q != min_q) begin
                     step_d = dn_next;
                  end else begin
                     dir_d   = 1'b1;
                     step_d  = up_next;
                     pdone_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         step_q  <= '0;
         min_q   <= '0;
         max_q   <= '0;
         inc_q   <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b1;
         upd_q   <= 1'b0;
         pdone_q <= 1'b0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         min_q   <= min_d;
         max_q   <= max_d;
         inc_q   <= inc_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         upd_q   <= upd_d;
         pdone_q <= pdone_d;
         cerr_q  <= cerr_d;
      end
   end

   assign bus.o_phase_count_step = step_q;
   assign bus.o_step_update      = upd_q;
   assign bus.o_busy             = (state_q != StIdle);
   assign bus.o_dir              = dir_q;
   assign bus.o_period_done      = pdone_q;
   assign bus.o_cfg_err          = cerr_q;
endmodule

// File: tb/tb_sweep_step_ctrl.sv
// Bench for sweep_step_ctrl: directed literal sequences plus randomized
// traffic checked every cycle against a behavioural sweep model.
module tb_sweep_step_ctrl;
   localparam int unsigned DEPTH   = 1024;
   localparam int unsigned DWELL_W = 16;
   localparam int unsigned AW      = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] val;
      logic        dir;
      logic        pd;
   } rule_t;

   logic clk;
   logic rst_n;

   sweep_step_ctrl_if #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) bus ();

   sweep_step_ctrl #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errs   = 0;
   int cyc_no   = 0;
   bit cmp_en   = 0;

   // Model state
   bit    m_busy, m_dir, m_upd, m_pd, m_err;
   int    m_val, m_left, c_min, c_max, c_inc, c_dw;
   rule_t r_nxt;

   // Captured loads
   int cap_v[$];
   int cap_d[$];
   int cap_p[$];
   int cap_c[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   // Sweep rule applied at a step event, from the bounds and the direction
   function automatic rule_t step_rule(input int cur, input bit up, input int mn, input int mx,
                                       input int inc);
      rule_t r;
      r.pd  = 1'b0;
      r.dir = up;
      if (up) begin
         if (cur != mx) begin
            r.val = (cur + inc > mx) ? mx : cur + inc;
         end else begin
`ifdef SWEEP_BIDIR_EN
            r.dir = 1'b0;
            r.val = (cur - inc < mn) ? mn : cur - inc;
`else
            r.val = mn;
            r.pd  = 1'b1;
`endif
         end
      end else if (cur != mn) begin
         r.val = (cur - inc < mn) ? mn : cur - inc;
      end else begin
         r.dir = 1'b1;
         r.val = (cur + inc > mx) ? mx : cur + inc;
         r.pd  = 1'b1;
      end
      return r;
   endfunction

   always_comb r_nxt = step_rule(m_val, m_dir, c_min, c_max, c_inc);

   // Behavioural model: m_left is the number of running cycles still owed
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_val <= 0; m_dir <= 1'b1; m_left <= 0;
         m_upd  <= 1'b0; m_pd  <= 1'b0; m_err <= 1'b0;
      end else begin
         m_upd <= 1'b0; m_pd <= 1'b0; m_err <= 1'b0;
         if (!m_busy) begin
            if (bus.i_start && !bus.i_stop) begin
               if ((int'(bus.i_step_min) > int'(bus.i_step_max)) || (bus.i_step_inc == 0)) begin
                  m_err <= 1'b1;
               end else begin
                  c_min  <= int'(bus.i_step_min);
                  c_max  <= int'(bus.i_step_max);
                  c_inc  <= int'(bus.i_step_inc);
                  c_dw   <= (bus.i_dwell == 0) ? 1 : int'(bus.i_dwell);
                  m_left <= (bus.i_dwell == 0) ? 1 : int'(bus.i_dwell);
                  m_val  <= int'(bus.i_step_min);
                  m_dir  <= 1'b1;
                  m_busy <= 1'b1;
                  m_upd  <= 1'b1;
               end
            end
         end else if (bus.i_stop) begin
            m_busy <= 1'b0;
         end else if (!bus.i_hold) begin
            if (m_left > 1) begin
               m_left <= m_left - 1;
            end else begin
               m_left <= c_dw;
               m_val  <= int'(r_nxt.val);
               m_dir  <= r_nxt.dir;
               m_pd   <= r_nxt.pd;
               m_upd  <= 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison and load capture, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         cyc_no++;
         chk("step",  int'(bus.o_phase_count_step), m_val);
         chk("busy",  int'(bus.o_busy), int'(m_busy));
         chk("dir",   int'(bus.o_dir), int'(m_dir));
         chk("upd",   int'(bus.o_step_update), int'(m_upd));
         chk("pdone", int'(bus.o_period_done), int'(m_pd));
         chk("cfgerr", int'(bus.o_cfg_err), int'(m_err));
         if (bus.o_step_update === 1'b1) begin
            cap_v.push_back(int'(bus.o_phase_count_step));
            cap_d.push_back(int'(bus.o_dir));
            cap_p.push_back(int'(bus.o_period_done));
            cap_c.push_back(cyc_no);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic set_cfg(input int mn, input int mx, input int inc, input int dw);
      bus.i_step_min = mn[AW-1:0];
      bus.i_step_max = mx[AW-1:0];
      bus.i_step_inc = inc[AW-1:0];
      bus.i_dwell    = dw[DWELL_W-1:0];
   endtask

   task automatic clear_cap();
      cap_v.delete(); cap_d.delete(); cap_p.delete(); cap_c.delete();
   endtask

   // Start a sweep, let nloads values load, then stop it
   task automatic run_seq(input int mn, input int mx, input int inc, input int dw,
                          input int nloads, output int st_cyc);
      clear_cap();
      set_cfg(mn, mx, inc, dw);
      bus.i_start = 1'b1;
      st_cyc = cyc_no;
      cyc();
      bus.i_start = 1'b0;
      repeat ((nloads - 1) * dw) cyc();
      bus.i_stop = 1'b1;
      cyc();
      bus.i_stop = 1'b0;
      cyc();
   endtask

   task automatic check_seq(input string tag, input int ev[$], input int ed[$], input int pdi,
                            input int d, input int st_cyc);
      chk({tag, "_nloads"}, cap_v.size(), ev.size());
      if (cap_c.size() > 0) chk({tag, "_latency"}, cap_c[0] - st_cyc, 1);
      for (int i = 0; i < ev.size() && i < cap_v.size(); i++) begin
         chk($sformatf("%s_val%0d", tag, i), cap_v[i], ev[i]);
         chk($sformatf("%s_dir%0d", tag, i), cap_d[i], ed[i]);
         chk($sformatf("%s_pd%0d", tag, i), cap_p[i], (i == pdi) ? 1 : 0);
         if (i > 0) chk($sformatf("%s_gap%0d", tag, i), cap_c[i] - cap_c[i-1], d);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ev[$];
      int ed[$];
      int pdi;
      int st;
      int prev;
      int len;
      bit found;

      rst_n = 1'b1;
      bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_hold = 1'b0;
      set_cfg(0, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();

      chk("rst_step", int'(bus.o_phase_count_step), 0);
      chk("rst_dir", int'(bus.o_dir), 1);
      chk("rst_busy", int'(bus.o_busy), 0);
      chk("rst_upd", int'(bus.o_step_update), 0);
      chk("rst_pd", int'(bus.o_period_done), 0);
      chk("rst_err", int'(bus.o_cfg_err), 0);

      // Main sweep shape
`ifdef SWEEP_BIDIR_EN
      ev = {10, 20, 30, 40, 30, 20, 10, 20}; ed = {1, 1, 1, 1, 0, 0, 0, 1}; pdi = 7;
`else
      ev = {10, 20, 30, 40, 10}; ed = {1, 1, 1, 1, 1}; pdi = 4;
`endif
      run_seq(10, 40, 10, 3, ev.size(), st);
      check_seq("shape", ev, ed, pdi, 3, st);

      // Clamp at the upper bound, one value per cycle
`ifdef SWEEP_BIDIR_EN
      ev = {0, 10, 20, 25, 15, 5, 0, 10}; ed = {1, 1, 1, 1, 0, 0, 0, 1}; pdi = 7;
`else
      ev = {0, 10, 20, 25, 0}; ed = {1, 1, 1, 1, 1}; pdi = 4;
`endif
      run_seq(0, 25, 10, 1, ev.size(), st);
      check_seq("clamp", ev, ed, pdi, 1, st);

      // Rejected configurations
      prev = int'(bus.o_phase_count_step);
      set_cfg(50, 40, 10, 3);
      bus.i_start = 1'b1;
      cyc();
      bus.i_start = 1'b0;
      chk("cerr_minmax_pulse", int'(bus.o_cfg_err), 1);
      chk("cerr_minmax_busy", int'(bus.o_busy), 0);
      chk("cerr_minmax_step", int'(bus.o_phase_count_step), prev);
      cyc();
      chk("cerr_minmax_clear", int'(bus.o_cfg_err), 0);
      set_cfg(10, 40, 0, 3);
      bus.i_start = 1'b1;
      cyc();
      bus.i_start = 1'b0;
      chk("cerr_inc0_pulse", int'(bus.o_cfg_err), 1);
      chk("cerr_inc0_busy", int'(bus.o_busy), 0);
      chk("cerr_inc0_step", int'(bus.o_phase_count_step), prev);
      cyc();

      // Hold for 5 cycles inside value 20, then stop
      set_cfg(10, 40, 10, 4);
      bus.i_start = 1'b1;
      cyc();
      bus.i_start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         cyc();
         if (bus.o_step_update && bus.o_phase_count_step == 20) found = 1'b1;
      end
      chk("hold_found20", int'(found), 1);
      len = 1;
      for (int k = 1; k < 30; k++) begin
         cyc();
         if (bus.o_phase_count_step != 20) break;
         len++;
         bus.i_hold = (k <= 5);
      end
      bus.i_hold = 1'b0;
      chk("hold_len20", len, 9);
      chk("hold_next30", int'(bus.o_phase_count_step), 30);
      bus.i_stop = 1'b1;
      cyc();
      bus.i_stop = 1'b0;
      chk("stop_busy", int'(bus.o_busy), 0);
      clear_cap();
      repeat (6) cyc();
      chk("stop_step", int'(bus.o_phase_count_step), 30);
      chk("stop_nopulse", cap_v.size(), 0);

      // Asynchronous reset in the middle of a sweep
      set_cfg(10, 40, 10, 2);
      bus.i_start = 1'b1;
      cyc();
      bus.i_start = 1'b0;
      repeat (7) cyc();
      rst_n = 1'b0;
      #1;
      chk("amid_step", int'(bus.o_phase_count_step), 0);
      chk("amid_busy", int'(bus.o_busy), 0);
      chk("amid_dir", int'(bus.o_dir), 1);
      chk("amid_upd", int'(bus.o_step_update), 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Start and stop together in IDLE
      set_cfg(10, 40, 10, 2);
      bus.i_start = 1'b1;
      bus.i_stop  = 1'b1;
      cyc();
      bus.i_start = 1'b0;
      bus.i_stop  = 1'b0;
      chk("ss_busy", int'(bus.o_busy), 0);
      chk("ss_upd", int'(bus.o_step_update), 0);
      chk("ss_step", int'(bus.o_phase_count_step), 0);
      cyc();
      chk("ss_busy2", int'(bus.o_busy), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         int mode, mn, mx, inc;
         mode = int'($urandom_range(0, 3));
         case (mode)
            0: begin
               mn = int'($urandom_range(0, 60)); mx = mn + int'($urandom_range(0, 60));
               inc = int'($urandom_range(1, 25));
            end
            1: begin
               mn = int'($urandom_range(950, 1023)); mx = int'($urandom_range(mn, 1023));
               inc = int'($urandom_range(1, 200));
            end
            2: begin
               mn = int'($urandom_range(41, 100)); mx = int'($urandom_range(0, 100));
               inc = int'($urandom_range(0, 3));
            end
            default: begin
               mn = int'($urandom_range(0, 1023)); mx = mn;
               inc = int'($urandom_range(1, 5));
            end
         endcase
         set_cfg(mn, mx, inc, int'($urandom_range(0, 3)));
         bus.i_start = ($urandom_range(0, 99) < 6);
         bus.i_stop  = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) == 0) bus.i_hold = ~bus.i_hold;
         cyc();
      end
      bus.i_start = 1'b0;
      bus.i_hold  = 1'b0;
      bus.i_stop  = 1'b1;
      cyc();
      bus.i_stop  = 1'b0;
      cyc();
      chk("final_busy", int'(bus.o_busy), 0);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
